// File: rtl/imul_pkg.sv
// Shared types and constants for the multiply-unit writeback buffer.
// The queue entry carries the destination tag, the 65-bit result and the 6 flag bits.
package imul_pkg;

    localparam int TAG_W_DEF = 9;
    localparam int RES_W     = 65;
    localparam int FLG_W     = 6;

    // Tags narrower than TAG_W_DEF are zero-extended into this field.
    typedef struct packed {
        logic [TAG_W_DEF-1:0] tag;
        logic [RES_W-1:0]     res;
        logic [FLG_W-1:0]     flg;
    } wb_ent_t;

    function automatic int popcount(input logic [31:0] bits);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + int'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/imul_wb_fifo.sv
// Circular queue of wb_ent_t with extra-MSB pointers; the head is presented
// combinationally and reads as all-zero while the queue is empty.
module imul_wb_fifo
    import imul_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  wb_ent_t       push_data_i,
    input  logic          pop_i,
    output wb_ent_t       head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_ent_t     mem_q [DEPTH];
    logic        full_s, empty_s, push_ok_s, pop_ok_s;

    // Status decode and pointer next-state.
    always_comb begin
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        push_ok_s = push_i & ~full_s;
        pop_ok_s  = pop_i & ~empty_s;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Head presentation and occupancy.
    always_comb begin
        if (empty_s) begin
            head_o = '0;
        end else begin
            head_o = mem_q[rd_ptr_q[AW-1:0]];
        end
        full_o  = full_s;
        empty_o = empty_s;
        count_o = wr_ptr_q - rd_ptr_q;
    end

    imul_wb_fifo_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push_i),
        .full_i (full_s)
    );

endmodule

// File: rtl/imul_wb_fifo_chk.sv
// Protocol checker for the writeback queue: a push must never meet a full queue.
module imul_wb_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push_i,
    input logic full_i
);

    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_i))
        else $error("imul_wb_fifo: push while full, entry discarded");

endmodule

// File: rtl/imul_wb_buf.sv
// Writeback buffer behind the fixed-latency multiply pipe: tracks issued tags,
// captures results as they emerge, and grants issue credit so the queue never overruns.
module imul_wb_buf
    import imul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_W_DEF,
    parameter int LAT   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    input  logic             iss_en,
    input  logic [TAG_W-1:0] iss_tag,
    output logic             iss_rdy,
    input  logic [RES_W-1:0] mul_res,
    input  logic [FLG_W-1:0] mul_flg,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic [RES_W-1:0] wb_res,
    output logic [FLG_W-1:0] wb_flg,
    input  logic             wb_ack,
    output logic             err_ovf
);

    logic [LAT-1:0]   v_q, v_d;
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];
    logic             err_ovf_q, err_ovf_d;

    logic             iss_rdy_s;
    logic             push_s;
    wb_ent_t          push_ent_s;
    wb_ent_t          head_s;
    logic             full_s, empty_s;
    logic [AW:0]      count_s;

    // Credit counts queued entries plus ops still in the pipe, all from registered state.
    always_comb begin
        iss_rdy_s = ~full_s && ((int'(count_s) + popcount(32'(v_q))) < DEPTH);
    end

    // Tag pipe advances only with clkEn, in lockstep with the multiply unit.
    always_comb begin
        v_d   = v_q;
        tag_d = tag_q;
        if (clkEn) begin
            v_d[0]   = iss_en & iss_rdy_s;
            tag_d[0] = iss_tag;
            for (int k = 1; k < LAT; k++) begin
                v_d[k]   = v_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
        end else begin
            v_d   = v_q;
            tag_d = tag_q;
        end
    end

    // Overflow flag is sticky until reset.
    always_comb begin
        if (iss_en && clkEn && !iss_rdy_s) begin
            err_ovf_d = 1'b1;
        end else begin
            err_ovf_d = err_ovf_q;
        end
    end

    // Pipe and error state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q       <= '0;
            err_ovf_q <= 1'b0;
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            v_q       <= v_d;
            tag_q     <= tag_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // Result capture at the pipe's last stage.
    always_comb begin
        push_s         = clkEn & v_q[LAT-1];
        push_ent_s.tag = TAG_W_DEF'(tag_q[LAT-1]);
        push_ent_s.res = mul_res;
        push_ent_s.flg = mul_flg;
    end

    imul_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (push_s),
        .push_data_i (push_ent_s),
        .pop_i       (wb_ack),
        .head_o      (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .count_o     (count_s)
    );

    // Output drive.
    always_comb begin
        iss_rdy  = iss_rdy_s;
        wb_valid = ~empty_s;
        wb_tag   = TAG_W'(head_s.tag);
        wb_res   = head_s.res;
        wb_flg   = head_s.flg;
        err_ovf  = err_ovf_q;
    end

endmodule

// File: tb/tb_imul_wb_buf.sv
// Randomized and directed bench for imul_wb_buf against a queue-based behavioural model.
module tb_imul_wb_buf;

    localparam int DEPTH = 4;
    localparam int TAG_W = 9;
    localparam int LAT   = 2;

    logic             clk     = 1'b0;
    logic             rst     = 1'b0;
    logic             clkEn   = 1'b0;
    logic             iss_en  = 1'b0;
    logic [TAG_W-1:0] iss_tag = '0;
    logic             iss_rdy;
    logic [64:0]      mul_res = '0;
    logic [5:0]       mul_flg = '0;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [64:0]      wb_res;
    logic [5:0]       wb_flg;
    logic             wb_ack  = 1'b0;
    logic             err_ovf;

    imul_wb_buf #(.DEPTH(DEPTH), .TAG_W(TAG_W), .LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .clkEn    (clkEn),
        .iss_en   (iss_en),
        .iss_tag  (iss_tag),
        .iss_rdy  (iss_rdy),
        .mul_res  (mul_res),
        .mul_flg  (mul_flg),
        .wb_valid (wb_valid),
        .wb_tag   (wb_tag),
        .wb_res   (wb_res),
        .wb_flg   (wb_flg),
        .wb_ack   (wb_ack),
        .err_ovf  (err_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [64:0]      res;
        logic [5:0]       flg;
    } ent_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        longint           cap;
    } pend_t;

    // Model: ops waiting for their capture edge, and completed results awaiting ack.
    ent_t   exp_q[$];
    pend_t  pend_q[$];
    longint edge_n = 0;
    logic   ovf_m  = 1'b0;
    bit     m_rdy;
    ent_t   m_e;
    pend_t  m_p;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Model update on each active edge, from pre-edge model state.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_rdy = (exp_q.size() + pend_q.size()) < DEPTH;
            if (wb_ack && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (clkEn) begin
                edge_n++;
                if (pend_q.size() > 0 && pend_q[0].cap == edge_n) begin
                    m_e.tag = pend_q[0].tag;
                    m_e.res = mul_res;
                    m_e.flg = mul_flg;
                    exp_q.push_back(m_e);
                    void'(pend_q.pop_front());
                end
                if (iss_en) begin
                    if (m_rdy) begin
                        m_p.tag = iss_tag;
                        m_p.cap = edge_n + LAT;
                        pend_q.push_back(m_p);
                    end else begin
                        ovf_m = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            exp_q.delete();
            pend_q.delete();
            ovf_m = 1'b0;
        end
        chk("wb_valid", 80'(wb_valid), 80'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("wb_tag", 80'(wb_tag), 80'(exp_q[0].tag));
            chk("wb_res", 80'(wb_res), 80'(exp_q[0].res));
            chk("wb_flg", 80'(wb_flg), 80'(exp_q[0].flg));
        end
        chk("iss_rdy", 80'(iss_rdy), 80'((exp_q.size() + pend_q.size()) < DEPTH));
        chk("err_ovf", 80'(err_ovf), 80'(ovf_m));
    end

    initial begin
        // Reset values
        step();
        chk("rst_valid", 80'(wb_valid), 80'(0));
        chk("rst_tag",   80'(wb_tag),   80'(0));
        chk("rst_res",   80'(wb_res),   80'(0));
        chk("rst_flg",   80'(wb_flg),   80'(0));
        chk("rst_rdy",   80'(iss_rdy),  80'(1));
        chk("rst_ovf",   80'(err_ovf),  80'(0));
        rst   = 1'b1;
        clkEn = 1'b1;
        step();

        // Single op: result presented three cycles after issue
        iss_en  = 1'b1;
        iss_tag = 9'h015;
        step();
        iss_en  = 1'b0;
        step();
        mul_res = 65'h0_0000_0000_0000_002A;
        mul_flg = 6'h05;
        step();
        mul_res = '0;
        mul_flg = '0;
        chk("single_valid", 80'(wb_valid), 80'(1));
        chk("single_tag",   80'(wb_tag),   80'(9'h015));
        chk("single_res",   80'(wb_res),   80'(65'h2A));
        chk("single_flg",   80'(wb_flg),   80'(6'h05));
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        chk("single_pop", 80'(wb_valid), 80'(0));

        // Fill to DEPTH, then an issue without credit
        for (int i = 1; i <= 4; i++) begin
            iss_en  = 1'b1;
            iss_tag = 9'(i);
            mul_res = 65'(i * 3);
            step();
        end
        chk("fill_rdy_low", 80'(iss_rdy), 80'(0));
        iss_tag = 9'h1FF;
        step();
        iss_en = 1'b0;
        chk("ovf_set", 80'(err_ovf), 80'(1));
        repeat (3) step();
        chk("fill_head", 80'(wb_tag), 80'(1));
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        chk("fill_credit_back", 80'(iss_rdy), 80'(1));
        chk("fill_next_head",   80'(wb_tag),  80'(2));
        wb_ack = 1'b1;
        repeat (4) step();
        wb_ack = 1'b0;
        chk("ovf_dropped", 80'(wb_valid), 80'(0));
        chk("ovf_sticky",  80'(err_ovf),  80'(1));

        // Reset mid-flight: two queued, one in the pipe
        for (int i = 0; i < 2; i++) begin
            iss_en  = 1'b1;
            iss_tag = 9'(8'h50 + i);
            step();
        end
        iss_en = 1'b0;
        repeat (2) step();
        iss_en  = 1'b1;
        iss_tag = 9'h0AA;
        step();
        iss_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk("mid_rst_valid", 80'(wb_valid), 80'(0));
        chk("mid_rst_rdy",   80'(iss_rdy),  80'(1));
        chk("mid_rst_ovf",   80'(err_ovf),  80'(0));
        step();
        rst = 1'b1;
        repeat (4) step();
        chk("mid_rst_nocap", 80'(wb_valid), 80'(0));

        // clkEn stall of five cycles stretches latency to LAT+1+5
        iss_en  = 1'b1;
        iss_tag = 9'h007;
        step();
        iss_en = 1'b0;
        clkEn  = 1'b0;
        repeat (5) step();
        clkEn = 1'b1;
        step();
        chk("stall_not_yet", 80'(wb_valid), 80'(0));
        mul_res = 65'h1_0000_0000_0000_0007;
        mul_flg = 6'h2A;
        step();
        chk("stall_valid", 80'(wb_valid), 80'(1));
        chk("stall_tag",   80'(wb_tag),   80'(9'h007));
        chk("stall_res",   80'(wb_res),   80'(65'h1_0000_0000_0000_0007));
        chk("stall_flg",   80'(wb_flg),   80'(6'h2A));
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;

        // Back-to-back push and pop once two entries are queued
        for (int i = 0; i < 14; i++) begin
            iss_en  = iss_rdy;
            iss_tag = 9'(9'h030 + i);
            mul_res = 65'(64'hC0DE_0000 + i);
            wb_ack  = (i >= 4);
            step();
        end
        iss_en = 1'b0;
        wb_ack = 1'b1;
        repeat (6) step();
        chk("pp_drained", 80'(wb_valid), 80'(0));
        chk("pp_no_ovf",  80'(err_ovf),  80'(0));

        // Randomized traffic with varying ack pressure
        for (int i = 0; i < 3000; i++) begin
            clkEn   = ($urandom_range(0, 7) != 0);
            iss_en  = ($urandom_range(0, 3) != 0);
            iss_tag = 9'($urandom);
            mul_res = {1'($urandom), $urandom, $urandom};
            mul_flg = 6'($urandom);
            if (((i / 150) % 2) == 0) begin
                wb_ack = ($urandom_range(0, 3) == 0);
            end else begin
                wb_ack = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        iss_en = 1'b0;
        clkEn  = 1'b1;
        wb_ack = 1'b1;
        repeat (10) step();
        chk("final_empty", 80'(wb_valid), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imul_wb_buf.md
# imul_wb_buf

Writeback buffer directly downstream of the integer multiply/sec/swap unit. It tracks the destination tag of every op issued into the fixed-latency multiply pipe and captures the unit's 65-bit result and 6-bit flags when they emerge. It queues up to DEPTH completed results and presents them in order to the shared writeback bus under a valid/ack handshake. It returns issue credit upstream so the multiply pipe, which has no backpressure, can never overrun the queue.

## Interface
- DEPTH, 4: result queue entries (power of two, ≥2)
- TAG_W, 9: destination register tag width
- LAT, 2: clkEn-qualified edges from issue to result-valid at the multiply unit's output
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- clkEn  in  1  pipeline advance; same signal that drives the multiply unit
- iss_en  in  1  op issued into multiply unit this cycle (qualified by clkEn)
- iss_tag  in  TAG_W  destination tag of issued op
- iss_rdy  out  1  credit available; upstream issues only when high
- mul_res  in  65  multiply unit result (bit 64 = pointer bit)
- mul_flg  in  6  multiply unit flags
- wb_valid  out  1  head entry valid
- wb_tag  out  TAG_W  head tag
- wb_res  out  65  head result
- wb_flg  out  6  head flags
- wb_ack  in  1  writeback bus accepts head this cycle
- err_ovf  out  1  sticky: issue attempted while iss_rdy low

## Operation
- Tag pipe: LAT stages of {v, tag}. On a clk edge with clkEn=1, stage1 ← {iss_en & iss_rdy, iss_tag}, and stage k ← stage k-1. With clkEn=0 the pipe holds.
- Capture: on a clk edge with clkEn=1 and stage LAT v=1, push {tag, mul_res, mul_flg} into the queue. Nothing is captured while clkEn=0.
- Queue: circular, with wr/rd pointers of log2(DEPTH)+1 bits. Full and empty are decoded from the MSB difference. Outputs are driven combinationally from the head entry; wb_valid = ~empty.
- Pop: at the edge where wb_valid & wb_ack, rd_ptr advances. wb_ack while empty is ignored.
- Credit: iss_rdy = (occupancy + popcount(pipe v)) < DEPTH, computed from registered state only. Same-cycle pops do not grant credit early.
- Overflow guard: iss_en & clkEn & ~iss_rdy drops the op (v=0 enters the pipe) and sets err_ovf. err_ovf clears only on reset.
- Simultaneous push and pop: both occur and occupancy is unchanged. Because of credit accounting, a push never meets a full queue. A push when full is an assertion failure, and that data is discarded.
- Results leave the buffer in strict issue order.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - all v = 0
  - pointers = 0
  - wb_valid = 0; wb_tag, wb_res, wb_flg = 0
  - iss_rdy = 1
  - err_ovf = 0
- Reset mid-operation discards in-flight and queued results.
- Issue at clkEn edge E0 → capture at clkEn edge E(LAT) → wb_valid high in the cycle after E(LAT).
  - With clkEn held high, total latency is LAT+1 cycles issue-to-wb_valid.
- A clkEn=0 gap stretches the latency by the gap length. The queue output side (pop) ignores clkEn.
- Throughput is one result per cycle in each direction.
- iss_rdy falls the cycle after the issue that consumes the last credit. It rises the cycle after the pop that frees one.

## Structure
- Shared package imul_pkg: TAG_W default, the result width (65) and flag width (6) constants, and the struct wb_ent_t {tag, res, flg}.
- One sub-module, imul_wb_fifo: parameterised circular queue of wb_ent_t with push/pop/full/empty/count.
- The top level holds the tag pipe, credit logic and err_ovf.

## Test plan
- Single op: issue tag=0x15 with clkEn=1, and drive mul_res=0x0_0000_0000_0000_002A, flg=0x05 at stage LAT → wb_valid rises 3 cycles after issue with tag 0x15, res 0x2A, flg 0x05. Ack → wb_valid=0 next cycle.
- Fill: wb_ack=0, issue tags 1..4 back-to-back → iss_rdy=0 after 4th issue (DEPTH=4). Queue holds 1..4 in order. Ack one → iss_rdy=1 the next cycle.
- clkEn stall: issue tag 7, hold clkEn=0 for 5 cycles after E0 → no capture during the stall. wb_valid asserts LAT+1+5 cycles after issue with the correct data.
- Simultaneous push/pop at occupancy 2 with continuous ack → occupancy stays 2. Output order is preserved and no entry is lost or duplicated.
- Overflow: with iss_rdy=0, assert iss_en → err_ovf=1 next cycle. The dropped op never appears. err_ovf stays 1 until rst.
- Reset mid-flight: 2 queued, 1 in pipe; pulse rst low for 1 cycle → wb_valid=0 and iss_rdy=1 immediately. The in-flight result is not captured after release.
